// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, imem request/response channel and the IF/ID register outputs.
// master is the fetch stage; slave is its environment (hazard unit, EX, instruction memory, decode).
interface if_fetch_stage_if;
  logic        ex_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  modport master (
    input  ex_stall, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_req_addr, if_id_valid, if_id_pc, if_id_instr
  );

  modport slave (
    output ex_stall, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_req_addr, if_id_valid, if_id_pc, if_id_instr
  );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32 fetch front end: one outstanding imem fetch, response lands in IF/ID the next cycle; ex_stall parks it in a
// 1-entry hold buffer, redirects flush. Optional perf counters with IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  if_fetch_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_req_q, pc_req_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;

  logic        req_vld;
  logic        req_acc;
  logic        deliver;
  logic [31:0] redirect_pc_al;
  logic        unused_redirect_lsbs;

  assign redirect_pc_al       = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  always_comb begin
    req_vld = 1'b0;
    unique case (state_q)
      S_REQ:   req_vld = !hold_valid_q && !bus.redirect_valid;
      // back-to-back request in the response cycle keeps the 1-cycle memory at full rate
      S_WAIT:  req_vld = bus.imem_rsp_valid && !bus.ex_stall && !hold_valid_q && !bus.redirect_valid;
      default: req_vld = 1'b0;
    endcase
    req_vld = req_vld && rst_n;
    req_acc = req_vld && bus.imem_req_ready;
    deliver = (state_q == S_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_id_valid    = if_id_valid_q;
  assign bus.if_id_pc       = if_id_pc_q;
  assign bus.if_id_instr    = if_id_instr_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_req_d      = pc_req_q;
    hold_valid_d  = hold_valid_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;

    unique case (state_q)
      S_REQ: begin
        if (req_acc) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          state_d = bus.imem_rsp_valid ? S_REQ : S_DROP;
        end else if (bus.imem_rsp_valid) begin
          state_d = req_acc ? S_WAIT : S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (req_acc) begin
      pc_req_d = pc_q;
      pc_d     = pc_q + 32'd4;
    end
    if (bus.redirect_valid) pc_d = redirect_pc_al;

    // IF/ID source priority: redirect flush, stall freeze, hold buffer, fresh response, bubble
    if (bus.redirect_valid) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP;
      hold_valid_d  = 1'b0;
    end else if (bus.ex_stall) begin
      if (deliver) begin
        hold_valid_d = 1'b1;
        hold_pc_d    = pc_req_q;
        hold_instr_d = bus.imem_rsp_data;
      end
    end else if (hold_valid_q) begin
      if_id_valid_d = 1'b1;
      if_id_pc_d    = hold_pc_q;
      if_id_instr_d = hold_instr_q;
      hold_valid_d  = 1'b0;
    end else if (deliver) begin
      if_id_valid_d = 1'b1;
      if_id_pc_d    = pc_req_q;
      if_id_instr_d = bus.imem_rsp_data;
    end else begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      pc_req_q      <= 32'h0;
      hold_valid_q  <= 1'b0;
      hold_pc_q     <= 32'h0;
      hold_instr_q  <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_req_q      <= pc_req_d;
      hold_valid_q  <= hold_valid_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (bus.ex_stall && !bus.redirect_valid) perf_stall_d = perf_stall_q + 32'd1;
    if (bus.redirect_valid) perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Fetch-stage bench: directed scenarios plus random stall/redirect/ready/latency traffic against a program-order
// model of requested addresses and IF/ID contents, with a latency-programmable instruction memory.
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_fetch_stage_if bus ();
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  logic [31:0] exp_stall_cnt, exp_flush_cnt;
`endif

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // stimulus for the next cycle
  logic        s_stall, s_redir, s_ready;
  logic [31:0] s_target;
  int          s_lat;
  // memory model: at most one fetch in flight
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  // program-order expectations
  logic [31:0] exp_req, exp_pc;
  logic        prev_valid;
  logic [31:0] prev_pc, prev_instr;
  int          delivered;
  logic        last_req_vld, last_acc;
  logic [31:0] last_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic tick();
    logic rsp;
    rsp = pend && (pend_cnt == 0);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(pend_addr) : $urandom;
    bus.ex_stall       = s_stall;
    bus.redirect_valid = s_redir;
    bus.redirect_pc    = s_target;
    bus.imem_req_ready = s_ready;
    #1;
    last_req_vld  = bus.imem_req_valid;
    last_req_addr = bus.imem_req_addr;
    last_acc      = (last_req_vld === 1'b1) && s_ready;
    if (s_redir) begin
      checks++;
      if (last_req_vld !== 1'b0) begin
        failures++; $display("FAIL req_during_redirect: got valid=%b need 0", last_req_vld);
      end
    end
    if (last_acc) begin
      checks++;
      if (pend && !rsp) begin
        failures++; $display("FAIL one_outstanding: request 0x%08h accepted while fetch 0x%08h in flight", last_req_addr, pend_addr);
      end
      checks++;
      if (last_req_addr !== exp_req) begin
        failures++; $display("FAIL req_addr: got 0x%08h need 0x%08h", last_req_addr, exp_req);
      end
      exp_req = exp_req + 32'd4;
    end
    if (s_redir) exp_req = {s_target[31:2], 2'b00};
    if (rsp) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (last_acc) begin
      pend = 1'b1; pend_cnt = s_lat - 1; pend_addr = last_req_addr;
    end

    @(posedge clk); #1;
    checks++;
    if (s_redir) begin
      if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP || bus.if_id_pc !== prev_pc) begin
        failures++; $display("FAIL redirect_bubble: got v=%b pc=0x%08h ins=0x%08h need v=0 pc=0x%08h ins=NOP",
                             bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, prev_pc);
      end
      exp_pc = {s_target[31:2], 2'b00};
    end else if (s_stall) begin
      if (bus.if_id_valid !== prev_valid || bus.if_id_pc !== prev_pc || bus.if_id_instr !== prev_instr) begin
        failures++; $display("FAIL stall_freeze: got v=%b pc=0x%08h need v=%b pc=0x%08h",
                             bus.if_id_valid, bus.if_id_pc, prev_valid, prev_pc);
      end
    end else if (bus.if_id_valid === 1'b1) begin
      if (bus.if_id_pc !== exp_pc || bus.if_id_instr !== mem_word(exp_pc)) begin
        failures++; $display("FAIL deliver: got pc=0x%08h ins=0x%08h need pc=0x%08h ins=0x%08h",
                             bus.if_id_pc, bus.if_id_instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end else begin
      if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP || bus.if_id_pc !== prev_pc) begin
        failures++; $display("FAIL bubble: got v=%b pc=0x%08h ins=0x%08h need v=0 pc=0x%08h ins=NOP",
                             bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, prev_pc);
      end
    end
`ifdef IF_PERF_CNT_EN
    if (s_stall && !s_redir) exp_stall_cnt++;
    if (s_redir) exp_flush_cnt++;
    checks++;
    if (perf_stall_cnt !== exp_stall_cnt || perf_flush_cnt !== exp_flush_cnt) begin
      failures++; $display("FAIL perf_cnt: got stall=%0d flush=%0d need stall=%0d flush=%0d",
                           perf_stall_cnt, perf_flush_cnt, exp_stall_cnt, exp_flush_cnt);
    end
`endif
    prev_valid = bus.if_id_valid; prev_pc = bus.if_id_pc; prev_instr = bus.if_id_instr;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s_stall = 1'b0; s_redir = 1'b0; s_ready = 1'b1; s_target = 32'h0; s_lat = 1;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0; bus.ex_stall = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.imem_req_ready = 1'b1;
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    exp_req = RST_PC; exp_pc = RST_PC;
    prev_valid = 1'b0; prev_pc = 32'h0; prev_instr = NOP;
`ifdef IF_PERF_CNT_EN
    exp_stall_cnt = 32'h0; exp_flush_cnt = 32'h0;
`endif
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid: got %b need 0", bus.imem_req_valid);
    end
    checks++;
    if (bus.if_id_valid !== 1'b0 || bus.if_id_pc !== 32'h0 || bus.if_id_instr !== NOP) begin
      failures++; $display("FAIL reset_if_id: got v=%b pc=0x%08h ins=0x%08h need v=0 pc=0 ins=NOP",
                           bus.if_id_valid, bus.if_id_pc, bus.if_id_instr);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
      failures++; $display("FAIL reset_perf: got %0d/%0d need 0/0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    release_reset();
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
      failures++; $display("FAIL first_req: got v=%b addr=0x%08h need v=1 addr=0x%08h",
                           bus.imem_req_valid, bus.imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        checks++;
        if (!last_acc || last_req_addr !== RST_PC + 32'(4 * i)) begin
          failures++; $display("FAIL stream_req%0d: got acc=%b addr=0x%08h need acc=1 addr=0x%08h",
                               i, last_acc, last_req_addr, RST_PC + 32'(4 * i));
        end
      end
      if (i > 0) begin
        checks++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== RST_PC + 32'(4 * (i - 1))) begin
          failures++; $display("FAIL stream_ifid%0d: got v=%b pc=0x%08h need v=1 pc=0x%08h",
                               i, bus.if_id_valid, bus.if_id_pc, RST_PC + 32'(4 * (i - 1)));
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] frozen_pc, p;
    frozen_pc = bus.if_id_pc;
    p = exp_pc;
    s_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (last_acc || bus.if_id_pc !== frozen_pc || bus.if_id_valid !== 1'b1) begin
        failures++; $display("FAIL stall_cycle%0d: got acc=%b pc=0x%08h need acc=0 pc=0x%08h",
                             i, last_acc, bus.if_id_pc, frozen_pc);
      end
    end
    s_stall = 1'b0;
    tick();
    checks++;
    if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== p || last_acc) begin
      failures++; $display("FAIL hold_release: got v=%b pc=0x%08h acc=%b need v=1 pc=0x%08h acc=0",
                           bus.if_id_valid, bus.if_id_pc, last_acc, p);
    end
    tick();
    checks++;
    if (!last_acc || last_req_addr !== p + 32'd4) begin
      failures++; $display("FAIL restart_req: got acc=%b addr=0x%08h need acc=1 addr=0x%08h", last_acc, last_req_addr, p + 32'd4);
    end
    tick();
    checks++;
    if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== p + 32'd4) begin
      failures++; $display("FAIL restart_ifid: got v=%b pc=0x%08h need v=1 pc=0x%08h", bus.if_id_valid, bus.if_id_pc, p + 32'd4);
    end
  endtask

  task automatic test_redirect_drop();
    bit got_acc;
    int acc_at;
    got_acc = 1'b0;
    s_lat = 3;
    for (int i = 0; i < 10 && !got_acc; i++) begin
      tick();
      got_acc = last_acc;
    end
    checks++;
    if (!got_acc) begin
      failures++; $display("FAIL drop_setup: got no accepted request need one within 10 cycles");
    end
    s_redir = 1'b1; s_target = 32'h0000_0203;
    tick();
    s_redir = 1'b0; s_lat = 1;
    acc_at = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (last_acc && acc_at < 0) begin
        acc_at = i;
        checks++;
        if (last_req_addr !== 32'h0000_0200) begin
          failures++; $display("FAIL redirect_req: got 0x%08h need 0x00000200", last_req_addr);
        end
      end
      if (bus.if_id_valid === 1'b1) break;
    end
    checks++;
    if (acc_at != 3) begin
      failures++; $display("FAIL drop_wait: got first request at cycle %0d need cycle 3", acc_at);
    end
    checks++;
    if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 32'h0000_0200) begin
      failures++; $display("FAIL redirect_target: got v=%b pc=0x%08h need v=1 pc=0x00000200", bus.if_id_valid, bus.if_id_pc);
    end
  endtask

  task automatic test_redirect_hold();
    bit seen;
    seen = 1'b0;
    s_lat = 1; s_stall = 1'b1;
    repeat (3) tick();
    s_redir = 1'b1; s_target = 32'h0000_0300;
    tick();
    checks++;
    if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP) begin
      failures++; $display("FAIL redir_stall_bubble: got v=%b ins=0x%08h need v=0 ins=NOP", bus.if_id_valid, bus.if_id_instr);
    end
    s_redir = 1'b0; s_stall = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = (bus.if_id_valid === 1'b1);
    end
    checks++;
    if (!seen || bus.if_id_pc !== 32'h0000_0300) begin
      failures++; $display("FAIL hold_discard: got v=%b pc=0x%08h need v=1 pc=0x00000300", bus.if_id_valid, bus.if_id_pc);
    end
  endtask

  task automatic test_ready_low();
    logic [31:0] a0;
    s_ready = 1'b0;
    tick();
    a0 = last_req_addr;
    checks++;
    if (last_req_vld !== 1'b1 || a0 !== exp_req) begin
      failures++; $display("FAIL ready_low_req: got v=%b addr=0x%08h need v=1 addr=0x%08h", last_req_vld, a0, exp_req);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (last_req_vld !== 1'b1 || last_req_addr !== a0 || last_acc) begin
        failures++; $display("FAIL ready_low_stable%0d: got v=%b addr=0x%08h need v=1 addr=0x%08h", i, last_req_vld, last_req_addr, a0);
      end
    end
    s_ready = 1'b1;
    tick();
    checks++;
    if (!last_acc || last_req_addr !== a0) begin
      failures++; $display("FAIL ready_high_acc: got acc=%b addr=0x%08h need acc=1 addr=0x%08h", last_acc, last_req_addr, a0);
    end
  endtask

  task automatic test_random();
    int start;
    start = delivered;
    for (int i = 0; i < 3000; i++) begin
      s_stall  = ($urandom_range(0, 3) == 0);
      s_redir  = ($urandom_range(0, 19) == 0);
      s_target = $urandom & 32'h0000_3FFF;
      s_ready  = ($urandom_range(0, 9) < 7);
      s_lat    = $urandom_range(1, 3);
      tick();
    end
    s_stall = 1'b0; s_redir = 1'b0; s_ready = 1'b1; s_lat = 1;
    checks++;
    if (delivered - start < 200) begin
      failures++; $display("FAIL random_progress: got %0d instructions need at least 200", delivered - start);
    end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    release_reset();
    s_stall = 1'b1;
    repeat (4) tick();
    s_stall = 1'b0; s_redir = 1'b1; s_target = 32'h0000_0400;
    repeat (2) tick();
    s_redir = 1'b0;
    checks++;
    if (perf_stall_cnt !== 32'd4 || perf_flush_cnt !== 32'd2) begin
      failures++; $display("FAIL perf_directed: got stall=%0d flush=%0d need 4/2", perf_stall_cnt, perf_flush_cnt);
    end
  endtask
`endif

  initial begin
    delivered = 0;
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_drop();
    test_redirect_hold();
    test_ready_low();
    test_random();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
